// File: rtl/spm_pkg.sv
// spm_stats shared types and helpers.
// State encoding, mode bits, header length, clear values.
package spm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    ACCUM,
    EMIT
  } state_t;

  localparam int MODE_SIGNED = 0;
  localparam int MODE_SUM    = 1;
  localparam int MAX_W       = 64;

  // mode word + total_frames + frames_per_interval
  function automatic int hdr_words(input int cnt_w);
    return 1 + 2 * (cnt_w / 16);
  endfunction

  function automatic logic [MAX_W-1:0] min_clr(
    input int   w,
    input logic s
  );
    logic [MAX_W-1:0] ones;
    ones = {MAX_W{1'b1}};
    ones = ones >> (MAX_W - w);
    return s ? (ones >> 1) : ones;
  endfunction

  function automatic logic [MAX_W-1:0] max_clr(
    input int   w,
    input logic s
  );
    logic [MAX_W-1:0] one;
    one = MAX_W'(1);
    return s ? (one << (w - 1)) : '0;
  endfunction

endpackage

// File: rtl/spm_stats_if.sv
// spm_stats streaming bus.
// Input and output valid/ready handshakes.
interface spm_stats_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] data_in;
  logic              data_in_available;
  logic              data_in_ready;
  logic [DATA_W-1:0] data_out;
  logic              data_out_ready;
  logic              data_out_available;

  modport slave (
    input  data_in,
    input  data_in_available,
    input  data_out_available,
    output data_in_ready,
    output data_out,
    output data_out_ready
  );

  modport master (
    output data_in,
    output data_in_available,
    output data_out_available,
    input  data_in_ready,
    input  data_out,
    input  data_out_ready
  );
endinterface

// File: rtl/spm_chan_acc.sv
// One channel of spm_stats.
// Holds min, max and running sum.
module spm_chan_acc
  import spm_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                update,
  input  logic                signed_mode,
  input  logic [DATA_W-1:0]   sample,
  output logic [DATA_W-1:0]   min_val,
  output logic [DATA_W-1:0]   max_val,
  output logic [2*DATA_W-1:0] sum_val
);

  logic                lt_min;
  logic                gt_max;
  logic [2*DATA_W-1:0] ext;

  always_comb begin
    lt_min = sample < min_val;
    gt_max = sample > max_val;
    ext    = {{DATA_W{1'b0}}, sample};
    if (signed_mode) begin
      lt_min = $signed(sample) < $signed(min_val);
      gt_max = $signed(sample) > $signed(max_val);
      ext    = {{DATA_W{sample[DATA_W-1]}}, sample};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      min_val <= DATA_W'(min_clr(DATA_W, 1'b0));
      max_val <= '0;
      sum_val <= '0;
    end else if (clear) begin
      min_val <= DATA_W'(min_clr(DATA_W, signed_mode));
      max_val <= DATA_W'(max_clr(DATA_W, signed_mode));
      sum_val <= '0;
    end else if (update) begin
      if (lt_min) min_val <= sample;
      if (gt_max) max_val <= sample;
      sum_val <= sum_val + ext;
    end
  end

endmodule

// File: rtl/spm_stats.sv
// Multi-channel min/max/sum statistics over a stream.
// Header parse, interleaved accumulate, per-interval emit.
module spm_stats
  import spm_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  spm_stats_if.slave bus,
  output logic       cfg_error
);

  localparam int HDR_N = hdr_words(CNT_W);
  localparam int HW    = CNT_W / 16;
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CH_W-1:0] CH_LAST  = CH_W'(CHANNELS - 1);
  localparam logic [7:0]      HDR_LAST = 8'(HDR_N - 1);
  localparam logic [7:0]      TOT_LAST = 8'(HW);

  state_t            state_q, state_d;
  logic              live_q;
  logic [7:0]        hdr_q, hdr_d;
  logic              sgn_q, sgn_d;
  logic              sum_q, sum_d;
  logic [CNT_W-1:0]  tot_q, tot_d;
  logic [CNT_W-1:0]  fpi_q, fpi_d, fpi_w;
  logic [CNT_W-1:0]  frm_q, frm_d, frm_nx;
  logic [CNT_W-1:0]  int_q, int_d, int_nx;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CH_W-1:0]   och_q, och_d;
  logic [1:0]        ow_q, ow_d;
  logic              err_d;
  logic              acc_clr;
  logic [CHANNELS-1:0] acc_upd;
  logic              in_fire, out_fire;
  logic              last_ch, last_och, last_w;

  logic [DATA_W-1:0]   mn [CHANNELS];
  logic [DATA_W-1:0]   mx [CHANNELS];
  logic [2*DATA_W-1:0] sm [CHANNELS];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    spm_chan_acc #(
      .DATA_W(DATA_W)
    ) u_acc (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (acc_clr),
      .update     (acc_upd[c]),
      .signed_mode(sgn_q),
      .sample     (bus.data_in),
      .min_val    (mn[c]),
      .max_val    (mx[c]),
      .sum_val    (sm[c])
    );
  end

  assign bus.data_in_ready  = live_q & enable
                            & (state_q != EMIT);
  assign bus.data_out_ready = enable & (state_q == EMIT);

  assign in_fire  = bus.data_in_available
                  & bus.data_in_ready;
  assign out_fire = bus.data_out_available
                  & bus.data_out_ready;
  assign last_ch  = ch_q == CH_LAST;
  assign last_och = och_q == CH_LAST;
  assign last_w   = ow_q == (sum_q ? 2'd3 : 2'd1);

  always_comb begin
    bus.data_out = '0;
    if (state_q == EMIT) begin
      unique case (ow_q)
        2'd0: bus.data_out = mn[och_q];
        2'd1: bus.data_out = mx[och_q];
        2'd2: bus.data_out = sm[och_q][DATA_W-1:0];
        2'd3: bus.data_out = sm[och_q][2*DATA_W-1:DATA_W];
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    sgn_d   = sgn_q;
    sum_d   = sum_q;
    tot_d   = tot_q;
    fpi_d   = fpi_q;
    frm_d   = frm_q;
    int_d   = int_q;
    ch_d    = ch_q;
    och_d   = och_q;
    ow_d    = ow_q;
    err_d   = 1'b0;
    acc_clr = 1'b0;
    acc_upd = '0;
    frm_nx  = frm_q + CNT_W'(1);
    int_nx  = int_q + CNT_W'(1);
    // header count fields shift in low word first
    fpi_w   = CNT_W'({bus.data_in[15:0], fpi_q} >> 16);
    case (state_q)
      IDLE: if (in_fire) begin
        sgn_d   = bus.data_in[MODE_SIGNED];
        sum_d   = bus.data_in[MODE_SUM];
        hdr_d   = 8'd1;
        state_d = HEADER;
      end
      HEADER: if (in_fire) begin
        hdr_d = hdr_q + 8'd1;
        if (hdr_q <= TOT_LAST)
          tot_d = CNT_W'({bus.data_in[15:0], tot_q} >> 16);
        else
          fpi_d = fpi_w;
        if (hdr_q == HDR_LAST) begin
          hdr_d = '0;
          if (tot_q == '0) begin
            err_d   = 1'b1;
            state_d = IDLE;
            sgn_d   = 1'b0;
            sum_d   = 1'b0;
            fpi_d   = '0;
          end else begin
            state_d = ACCUM;
            acc_clr = 1'b1;
            if (fpi_w == '0) fpi_d = tot_q;
          end
        end
      end
      ACCUM: if (in_fire) begin
        acc_upd = CHANNELS'(1) << ch_q;
        if (last_ch) begin
          ch_d  = '0;
          frm_d = frm_nx;
          int_d = int_nx;
          if (int_nx == fpi_q || frm_nx == tot_q) begin
            state_d = EMIT;
            och_d   = '0;
            ow_d    = '0;
          end
        end else begin
          ch_d = ch_q + CH_W'(1);
        end
      end
      EMIT: if (out_fire) begin
        if (!last_w) begin
          ow_d = ow_q + 2'd1;
        end else begin
          ow_d = '0;
          if (!last_och) begin
            och_d = och_q + CH_W'(1);
          end else begin
            och_d   = '0;
            int_d   = '0;
            acc_clr = 1'b1;
            if (frm_q == tot_q) begin
              state_d = IDLE;
              sgn_d   = 1'b0;
              sum_d   = 1'b0;
              tot_d   = '0;
              fpi_d   = '0;
              frm_d   = '0;
            end else begin
              state_d = ACCUM;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      live_q    <= 1'b0;
      hdr_q     <= '0;
      sgn_q     <= 1'b0;
      sum_q     <= 1'b0;
      tot_q     <= '0;
      fpi_q     <= '0;
      frm_q     <= '0;
      int_q     <= '0;
      ch_q      <= '0;
      och_q     <= '0;
      ow_q      <= '0;
      cfg_error <= 1'b0;
    end else begin
      state_q   <= state_d;
      live_q    <= 1'b1;
      hdr_q     <= hdr_d;
      sgn_q     <= sgn_d;
      sum_q     <= sum_d;
      tot_q     <= tot_d;
      fpi_q     <= fpi_d;
      frm_q     <= frm_d;
      int_q     <= int_d;
      ch_q      <= ch_d;
      och_q     <= och_d;
      ow_q      <= ow_d;
      cfg_error <= err_d;
    end
  end

endmodule
